// File: rtl/bufhce_ce_sequencer.sv
// Clock-enable sequencer for a BUFHCE CE pin: arm delay, minimum on-time,
// drain delay before ack drops, forced-off path and an enable-event counter.
module bufhce_ce_sequencer #(
    parameter int ON_DLY  = 4,
    parameter int MIN_ON  = 8,
    parameter int OFF_DLY = 3,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_req,
    input  logic        force_off,
    output logic        ce,
    output logic        ack,
    output logic        busy,
    output logic [1:0]  state,
    output logic        abort,
    output logic [15:0] en_cnt
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ARM   = 2'd1,
        S_ON    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MIN_MAX  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DLY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic [15:0]      en_cnt_q, en_cnt_d;
    logic             on_met;

    // cnt_q counts ON cycles already completed; the current cycle is the
    // MIN_ON-th one when cnt_q reaches MIN_ON-1, so leaving here keeps ce high
    // for exactly MIN_ON cycles.  The counter saturates at MIN_ON.
    assign on_met = (cnt_q == MIN_LAST) || (cnt_q == MIN_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_cnt_d = en_cnt_q;
        case (state_q)
            S_OFF: begin
                if (en_req && !force_off) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (!en_req || force_off) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d  = S_ON;
                    cnt_d    = '0;
                    en_cnt_d = en_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_ON: begin
                if (force_off || (!en_req && on_met)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q != MIN_MAX) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DRAIN: begin
                // Requests are ignored here: the drain always runs to completion.
                if (cnt_q == OFF_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs decode the next state so they move on the same edge as state.
        ce_d    = (state_d == S_ON);
        ack_d   = (state_d == S_ON) || (state_d == S_DRAIN);
        busy_d  = (state_d == S_ARM) || (state_d == S_DRAIN);
        abort_d = (state_q == S_ARM) && (state_d == S_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
            en_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            abort_q  <= abort_d;
            en_cnt_q <= en_cnt_d;
        end
    end

    assign ce     = ce_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign state  = state_q;
    assign abort  = abort_q;
    assign en_cnt = en_cnt_q;

endmodule

// File: tb/tb_bufhce_ce_sequencer.sv
// Scenario bench for bufhce_ce_sequencer: expected per-edge output frames are
// queued when stimulus is driven and compared as each edge completes.
module tb_bufhce_ce_sequencer;

    localparam int MIN_ON = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_req = 1'b0;
    logic        force_off = 1'b0;
    logic        ce, ack, busy, abort;
    logic [1:0]  state;
    logic [15:0] en_cnt;

    int checks = 0;
    int errors = 0;

    typedef enum int {S_CE, S_ACK, S_BUSY, S_STATE, S_ABORT, S_ENCNT} sel_t;
    typedef struct {
        string       name;
        int          at;
        sel_t        sel;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    bufhce_ce_sequencer #(.ON_DLY(4), .MIN_ON(MIN_ON), .OFF_DLY(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en_req(en_req), .force_off(force_off),
        .ce(ce), .ack(ack), .busy(busy), .state(state), .abort(abort), .en_cnt(en_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] peek(sel_t s);
        case (s)
            S_CE:    return {15'd0, ce};
            S_ACK:   return {15'd0, ack};
            S_BUSY:  return {15'd0, busy};
            S_STATE: return {14'd0, state};
            S_ABORT: return {15'd0, abort};
            default: return en_cnt;
        endcase
    endfunction

    function automatic void push(string n, int at, sel_t s, int v);
        sb.push_back('{name: n, at: at, sel: s, exp: 16'(v)});
    endfunction

    // One expected output frame; ce/ack/busy follow the per-state output table.
    function automatic void push_frame(string n, int e, int st, int ab, int cnt);
        push({n, "_state"}, e, S_STATE, st);
        push({n, "_ce"},    e, S_CE,    (st == 2) ? 1 : 0);
        push({n, "_ack"},   e, S_ACK,   (st >= 2) ? 1 : 0);
        push({n, "_busy"},  e, S_BUSY,  (st == 1 || st == 3) ? 1 : 0);
        push({n, "_abort"}, e, S_ABORT, ab);
        push({n, "_encnt"}, e, S_ENCNT, cnt);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en_req = 1'b0;
        force_off = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if ({ce, ack, busy, abort} !== 4'b0000 || state !== 2'd0 || en_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: got ce=%b ack=%b busy=%b abort=%b state=%0d en_cnt=%0h expected all 0",
                     ce, ack, busy, abort, state, en_cnt);
        end
        do_reset();
        for (int e = 1; e <= 10; e++) push_frame("reset_idle", e, 0, 0, 0);
        for (int rel = 1; rel <= 10; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL reset_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int e = 1; e <= 10; e++) push_frame("nom_idle", e, 0, 0, 0);
        for (int rel = 1; rel <= 36; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 10) begin
                en_req = 1'b1;
                for (int e = 11; e <= 30; e++) push_frame("nom_start", e, (e < 15) ? 1 : 2, 0, (e >= 15) ? 1 : 0);
            end
            if (rel == 30) begin
                en_req = 1'b0;
                for (int e = 31; e <= 36; e++) push_frame("nom_stop", e, (e < 34) ? 3 : 0, 0, 1);
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL nom_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_min_on();
        int ce_hi = 0;
        do_reset();
        for (int rel = 1; rel <= 28; rel++) begin
            @(posedge clk); #1;
            if (ce) ce_hi++;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 10) begin
                en_req = 1'b1;
                for (int e = 11; e <= 16; e++) push_frame("minon_start", e, (e < 15) ? 1 : 2, 0, (e >= 15) ? 1 : 0);
            end
            if (rel == 16) begin
                en_req = 1'b0;
                for (int e = 17; e <= 28; e++)
                    push_frame("minon_hold", e, (e < 23) ? 2 : (e < 26) ? 3 : 0, 0, 1);
            end
        end
        checks++;
        if (ce_hi !== MIN_ON) begin
            errors++;
            $display("FAIL minon_width: got %0d ce-high cycles expected %0d", ce_hi, MIN_ON);
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL minon_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_abort();
        do_reset();
        for (int rel = 1; rel <= 20; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 10) begin
                en_req = 1'b1;
                push_frame("abort_arm", 11, 1, 0, 0);
                push_frame("abort_arm", 12, 1, 0, 0);
            end
            if (rel == 12) begin
                en_req = 1'b0;
                for (int e = 13; e <= 20; e++) push_frame("abort_off", e, 0, (e == 13) ? 1 : 0, 0);
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL abort_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_force_off();
        do_reset();
        for (int rel = 1; rel <= 28; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 10) begin
                en_req = 1'b1;
                for (int e = 11; e <= 17; e++) push_frame("force_start", e, (e < 15) ? 1 : 2, 0, (e >= 15) ? 1 : 0);
            end
            if (rel == 17) begin
                force_off = 1'b1;
                for (int e = 18; e <= 28; e++)
                    push_frame("force_rereq", e, (e < 21) ? 3 : (e == 21) ? 0 : (e < 26) ? 1 : 2, 0, (e >= 26) ? 2 : 1);
            end
            if (rel == 18) force_off = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL force_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int rel = 1; rel <= 12; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 2) begin
                en_req = 1'b1;
                force_off = 1'b1;
                for (int e = 3; e <= 6; e++) push_frame("simul_hold", e, 0, 0, 0);
            end
            if (rel == 6) begin
                force_off = 1'b0;
                push_frame("simul_arm", 7, 1, 0, 0);
                push_frame("simul_arm", 8, 1, 0, 0);
            end
            if (rel == 8) begin
                force_off = 1'b1;
                push_frame("simul_kill", 9, 0, 1, 0);
                push_frame("simul_kill", 10, 0, 0, 0);
            end
            if (rel == 10) begin
                force_off = 1'b0;
                en_req = 1'b0;
                push_frame("simul_idle", 11, 0, 0, 0);
                push_frame("simul_idle", 12, 0, 0, 0);
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL simul_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int rel = 1; rel <= 28; rel++) begin
            @(posedge clk); #1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].at == rel) begin
                    checks++;
                    if (peek(sb[i].sel) !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h", sb[i].name, rel, peek(sb[i].sel), sb[i].exp);
                    end
                    sb.delete(i);
                end
            if (rel == 10) begin
                en_req = 1'b1;
                for (int e = 11; e <= 20; e++) push_frame("arst_run", e, (e < 15) ? 1 : 2, 0, (e >= 15) ? 1 : 0);
            end
            if (rel == 20) begin
                #3 rst = 1'b1;
                #1;
                checks += 4;
                if (ce !== 1'b0 || ack !== 1'b0 || en_cnt !== 16'd0 || state !== 2'd0) begin
                    errors++;
                    $display("FAIL arst_mid_on: got ce=%b ack=%b state=%0d en_cnt=%0h expected 0 0 0 0",
                             ce, ack, state, en_cnt);
                end
                push_frame("arst_held", 21, 0, 0, 0);
                push_frame("arst_held", 22, 0, 0, 0);
            end
            if (rel == 22) begin
                rst = 1'b0;
                for (int e = 23; e <= 28; e++) push_frame("arst_restart", e, (e < 27) ? 1 : 2, 0, (e >= 27) ? 1 : 0);
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL arst_sb: %0d unreached, expected 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_min_on();
        test_abort();
        test_force_off();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
